// File: rtl/seq_cska_pkg.sv
// Purpose: shared types and sizing helpers for the block-serial carry-skip adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_e  - controller states IDLE / RUN / DONE
//   num_blk  - number of skip blocks for a given operand width and block width
//   idx_w    - width of a register able to index n blocks (never below 1 bit)
package seq_cska_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_BLOCK_W = 4;

    function automatic int num_blk(input int width, input int block_w);
        return width / block_w;
    endfunction

    // $clog2(1) is 0, which would give a zero-width index for a single block.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_cska_block.sv
// Purpose: one combinational carry-skip block (ripple sum plus skip mux on the carry-out).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   a_blk, b_blk - BLOCK_W-bit operand slices
//   c_in         - carry into the block
//   s_blk        - BLOCK_W-bit sum slice
//   c_out        - block carry-out, taken from c_in when the whole block propagates
//   p_all        - 1 when every bit of the block propagates (a ^ b all ones)
//   c_msb        - ripple carry into the most significant bit of the block
module cska_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a_blk,
    input  logic [BLOCK_W-1:0] b_blk,
    input  logic               c_in,
    output logic [BLOCK_W-1:0] s_blk,
    output logic               c_out,
    output logic               p_all,
    output logic               c_msb
);

    logic [BLOCK_W-1:0] prop;
    logic [BLOCK_W-1:0] gen;

    assign prop  = a_blk ^ b_blk;
    assign gen   = a_blk & b_blk;
    assign p_all = &prop;

    always_comb begin
        logic [BLOCK_W:0] c;
        c     = '0;
        s_blk = '0;
        c[0]  = c_in;
        for (int i = 0; i < BLOCK_W; i++) begin
            s_blk[i] = prop[i] ^ c[i];
            c[i+1]   = gen[i] | (prop[i] & c[i]);
        end
        c_msb = c[BLOCK_W-1];
        // When every bit propagates the ripple carry-out equals c_in, so the
        // skip path lets the carry bypass the chain without changing the value.
        c_out = p_all ? c_in : c[BLOCK_W];
    end

endmodule

// File: rtl/seq_cska.sv
// Purpose: block-serial carry-skip adder, one BLOCK_W slice per clock, signed/unsigned with overflow.
// Latency: out_valid rises NUM_BLK cycles after the accept edge; back-to-back gives one result per NUM_BLK+1 cycles.
// Backpressure: result held in DONE while out_ready=0; in_ready only when idle or when the result is being taken.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, cin, is_signed sampled on accept)
//   out_valid / out_ready- result handshake
//   sum[WIDTH:0]         - result; top bit is carry-out (unsigned) or sign extension (signed)
//   ovf                  - two's-complement overflow, always 0 in unsigned mode
//   skip_cnt             - (only with SEQ_CSKA_SKIP_CNT_EN defined) number of fully
//                          propagating blocks in the current operation
//
// Build option: define SEQ_CSKA_SKIP_CNT_EN to add the skip_cnt output and its counter.
module seq_cska
    import seq_cska_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int BLOCK_W = DEF_BLOCK_W,
    localparam int NUM_BLK = num_blk(WIDTH, BLOCK_W),
    localparam int IDX_W   = idx_w(NUM_BLK),
    localparam int CNT_W   = $clog2(NUM_BLK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
`ifdef SEQ_CSKA_SKIP_CNT_EN
    ,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    if (BLOCK_W < 1 || WIDTH < BLOCK_W || (WIDTH % BLOCK_W) != 0) begin : g_bad_width
        $error("seq_cska: WIDTH must be a non-zero multiple of BLOCK_W");
    end

    state_e             state;
    logic [IDX_W-1:0]   k;
    logic               carry;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               signed_r;

    logic [BLOCK_W-1:0] a_blk;
    logic [BLOCK_W-1:0] b_blk;
    logic [BLOCK_W-1:0] s_blk;
    logic               c_out;
    logic               p_all;
    logic               c_msb;
    logic               accept;
    logic               last_blk;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign last_blk = (k == IDX_W'(NUM_BLK - 1));

    // Select the operand slice for the current block; indices past NUM_BLK-1
    // never occur, so the default zero is only a don't-care filler.
    always_comb begin
        a_blk = '0;
        b_blk = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            if (k == IDX_W'(i)) begin
                a_blk = a_r[i*BLOCK_W +: BLOCK_W];
                b_blk = b_r[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

    cska_block #(
        .BLOCK_W (BLOCK_W)
    ) u_blk (
        .a_blk (a_blk),
        .b_blk (b_blk),
        .c_in  (carry),
        .s_blk (s_blk),
        .c_out (c_out),
        .p_all (p_all),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            signed_r  <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_CSKA_SKIP_CNT_EN
            skip_cnt  <= '0;
`endif
        end else if (accept) begin
            // Accept can happen from IDLE or from DONE while the result is
            // being taken; both drop out_valid and restart at block 0.
            a_r       <= a;
            b_r       <= b;
            signed_r  <= is_signed;
            carry     <= cin;
            k         <= '0;
            out_valid <= 1'b0;
            state     <= RUN;
`ifdef SEQ_CSKA_SKIP_CNT_EN
            skip_cnt  <= '0;
`endif
        end else begin
            case (state)
                RUN: begin
                    for (int i = 0; i < NUM_BLK; i++) begin
                        if (k == IDX_W'(i)) begin
                            sum[i*BLOCK_W +: BLOCK_W] <= s_blk;
                        end
                    end
                    carry <= c_out;
`ifdef SEQ_CSKA_SKIP_CNT_EN
                    if (p_all) begin
                        skip_cnt <= skip_cnt + CNT_W'(1);
                    end
`endif
                    if (last_blk) begin
                        // Signed: the true sign of the (WIDTH+1)-bit result is
                        // a_msb ^ b_msb ^ carry-out; overflow is a mismatch
                        // between the carries into and out of the MSB.
                        if (signed_r) begin
                            sum[WIDTH] <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ c_out;
                            ovf        <= c_msb ^ c_out;
                        end else begin
                            sum[WIDTH] <= c_out;
                            ovf        <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef SEQ_CSKA_SKIP_CNT_EN
    // Without the counter the propagate flag only feeds the skip mux inside
    // the block; keep it referenced so the port is not left dangling.
    logic unused_p_all;
    assign unused_p_all = p_all;
`endif

endmodule

// File: tb/tb_seq_cska.sv
// Purpose: randomized, self-checking bench for seq_cska against an arithmetic reference model.
// Latency: checks NUM_BLK-cycle result latency and the one-cycle drop of out_valid.
// Backpressure: holds out_ready low in DONE and checks result stability and in_ready.
module tb_seq_cska;

    localparam int W   = 16;
    localparam int BW  = 4;
    localparam int NB  = W / BW;
    localparam int W1  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main DUT (16-bit, 4-bit blocks)
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cin = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          ovf;
    logic [W:0]    sum;

    // Single-block DUT (8-bit, 8-bit block)
    logic          in_valid1 = 1'b0;
    logic          out_ready1 = 1'b0;
    logic          cin1 = 1'b0;
    logic          is_signed1 = 1'b0;
    logic [W1-1:0] a1 = '0;
    logic [W1-1:0] b1 = '0;
    logic          in_ready1;
    logic          out_valid1;
    logic          ovf1;
    logic [W1:0]   sum1;

`ifdef SEQ_CSKA_SKIP_CNT_EN
    logic [$clog2(NB+1)-1:0] skip_cnt;
    logic [0:0]              skip_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Expected values of the operation in flight on the main DUT
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic         exp_c;
    logic         exp_s;

    always #5 clk = ~clk;

    seq_cska #(.WIDTH(W), .BLOCK_W(BW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
`ifdef SEQ_CSKA_SKIP_CNT_EN
        ,
        .skip_cnt  (skip_cnt)
`endif
    );

    seq_cska #(.WIDTH(W1), .BLOCK_W(W1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .is_signed (is_signed1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .ovf       (ovf1)
`ifdef SEQ_CSKA_SKIP_CNT_EN
        ,
        .skip_cnt  (skip_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Integer value of the operation: operands interpreted as signed or
    // unsigned numbers, then added with the carry-in.
    function automatic longint ref_val(input longint x, input longint y, input logic c,
                                       input logic sg, input int w);
        longint xv;
        longint yv;
        xv = x;
        yv = y;
        if (sg && x[w-1]) xv = x - (longint'(1) << w);
        if (sg && y[w-1]) yv = y - (longint'(1) << w);
        return xv + yv + longint'(c);
    endfunction

    function automatic logic [63:0] ref_sum(input longint x, input longint y, input logic c,
                                            input logic sg, input int w);
        longint s;
        s = ref_val(x, y, c, sg, w);
        return 64'(s & ((longint'(1) << (w + 1)) - 1));
    endfunction

    function automatic logic ref_ovf(input longint x, input longint y, input logic c,
                                     input logic sg, input int w);
        longint s;
        s = ref_val(x, y, c, sg, w);
        return sg && ((s > (longint'(1) << (w - 1)) - 1) || (s < -(longint'(1) << (w - 1))));
    endfunction

    function automatic int ref_skips(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        logic [W-1:0] d;
        n = 0;
        d = x ^ y;
        for (int i = 0; i < NB; i++) begin
            if (((d >> (i * BW)) & ((1 << BW) - 1)) == (1 << BW) - 1) n++;
        end
        return n;
    endfunction

    // Drive operands for one cycle; caller sits #1 after a rising edge and
    // must already see in_ready high. Inputs are scrambled afterwards.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts);
        check("in_ready_at_launch", 64'(in_ready), 64'd1);
        a = ta; b = tb; cin = tc; is_signed = ts; in_valid = 1'b1;
        exp_a = ta; exp_b = tb; exp_c = tc; exp_s = ts;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NB));
        check({tag, "_sum"}, 64'(sum), ref_sum(longint'(exp_a), longint'(exp_b), exp_c, exp_s, W));
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(longint'(exp_a), longint'(exp_b), exp_c, exp_s, W)));
`ifdef SEQ_CSKA_SKIP_CNT_EN
        check({tag, "_skip"}, 64'(skip_cnt), 64'(ref_skips(exp_a, exp_b)));
`endif
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W:0] held;
        int d;
        int t1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
`ifdef SEQ_CSKA_SKIP_CNT_EN
        check("rst_skip", 64'(skip_cnt), 64'd0);
`endif
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: unsigned carry out of the top
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        collect("t1");
        check("t1_sum_const", 64'(sum), 64'h10000);
        release_out();

        // 2: signed overflow and signed negative without overflow
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        collect("t2a");
        check("t2a_ovf_const", 64'(ovf), 64'd1);
        release_out();
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        collect("t2b");
        check("t2b_sum_const", 64'(sum), 64'h1FFFE);
        release_out();

        // 3: backpressure, then back-to-back accept in DONE
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        collect("t3");
        held = sum;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t3_hold_sum", 64'(sum), 64'h05555);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #0;
        launch(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("t3_b2b_drop", 64'(out_valid), 64'd0);
        // 4: full-propagate chain, launched back-to-back above
        collect("t4");
        check("t4_sum_const", 64'(sum), 64'h10000);
        release_out();

        // 5: reset in the middle of an operation
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_mid_valid", 64'(out_valid), 64'd0);
        check("t5_mid_low_sum", 64'(sum[7:0]), 64'h33);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_sum", 64'(sum), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        launch(16'h0003, 16'h0004, 1'b0, 1'b0);
        collect("t5");
        check("t5_sum_const", 64'(sum), 64'h00007);
        release_out();

        // Randomized operations with random backpressure and chaining
        for (int i = 0; i < 40; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            collect("rnd");
            held = sum;
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                @(posedge clk); #1;
                check("rnd_hold", 64'(sum), 64'(held));
            end
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
                #0;
                launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                out_ready = 1'b0;
                check("rnd_b2b_drop", 64'(out_valid), 64'd0);
                collect("rnd_b2b");
            end
            release_out();
        end

        // 6: single-block configuration
        a1 = 8'hAA; b1 = 8'h55; cin1 = 1'b1; is_signed1 = 1'b0;
        check("t6_in_ready", 64'(in_ready1), 64'd1);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("t6_valid_early", 64'(out_valid1), 64'd0);
        @(posedge clk); #1;
        check("t6_valid", 64'(out_valid1), 64'd1);
        check("t6_sum", 64'(sum1), 64'h100);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("t6_drop", 64'(out_valid1), 64'd0);

        for (int i = 0; i < 12; i++) begin
            logic [W1-1:0] ra;
            logic [W1-1:0] rb;
            logic          rc;
            logic          rs;
            ra = W1'($urandom); rb = W1'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            a1 = ra; b1 = rb; cin1 = rc; is_signed1 = rs;
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            a1 = W1'($urandom);
            t1 = 0;
            while (!out_valid1 && t1 < 10) begin
                @(posedge clk); #1;
                t1++;
            end
            check("s1_latency", 64'(t1), 64'd1);
            check("s1_sum", 64'(sum1), ref_sum(longint'(ra), longint'(rb), rc, rs, W1));
            check("s1_ovf", 64'(ovf1), 64'(ref_ovf(longint'(ra), longint'(rb), rc, rs, W1)));
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
